// File: rtl/s_mem_pkg.sv
// Shared types and helpers for the S-memory init and shuffle FSMs.
package s_mem_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned KEY_LEN = 3;

  typedef enum logic [3:0] {
    StIdle,
    StRdI,
    StWtI,
    StCalcJ,
    StRdJ,
    StWtJ,
    StWrI,
    StWrJ,
    StDone
  } shuffle_state_t;

  // Byte 0 is the most significant byte of the key.
  function automatic logic [DATA_W-1:0] key_byte(input logic [KEY_LEN*DATA_W-1:0] key,
                                                  input logic [1:0]                 idx);
    logic [DATA_W-1:0] b;
    unique case (idx)
      2'd0:    b = key[23:16];
      2'd1:    b = key[15:8];
      default: b = key[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/s_mem_shuffle_if.sv
// Control and S-memory port bundle for the RC4 key-scheduling shuffle.
interface s_mem_shuffle_if #(
  parameter int unsigned KEY_W = 24
);
  import s_mem_pkg::*;

  logic              start;
  logic [KEY_W-1:0]  secret_key;
  logic [DATA_W-1:0] q;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wen;
  logic              mem_req;
  logic              busy;
  logic              finish;

  modport master (
    output start, secret_key, q,
    input  address, data, wen, mem_req, busy, finish
  );

  modport slave (
    input  start, secret_key, q,
    output address, data, wen, mem_req, busy, finish
  );

endinterface

// File: rtl/s_mem_shuffle.sv
// RC4 key-scheduling shuffle over a 256-byte single-port S memory.
module s_mem_shuffle
  import s_mem_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned KEY_W      = 24
) (
  input logic           clk,
  input logic           reset,
  s_mem_shuffle_if.slave bus
);

  localparam int unsigned WaitW = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

  shuffle_state_t    state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d, j_q, j_d;
  logic [1:0]        key_idx_q, key_idx_d;
  logic [DATA_W-1:0] si_q, si_d, sj_q, sj_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wen_q, wen_d;
  logic              busy_q, busy_d;
  logic              finish_q, finish_d;
  logic              wait_last;

  assign wait_last = (wait_q == WaitW'(MEM_RD_LAT - 1));

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    key_idx_d = key_idx_q;
    si_d      = si_q;
    sj_d      = sj_q;
    wait_d    = '0;
    key_d     = key_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          key_d     = bus.secret_key;
          i_d       = '0;
          j_d       = '0;
          key_idx_d = '0;
          state_d   = StRdI;
        end
      end
      StRdI: state_d = StWtI;
      StWtI: begin
        if (wait_last) begin
          si_d    = bus.q;
          state_d = StCalcJ;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StCalcJ: begin
        j_d     = j_q + si_q + key_byte(key_q[KEY_LEN*DATA_W-1:0], key_idx_q);
        state_d = StRdJ;
      end
      StRdJ: state_d = StWtJ;
      StWtJ: begin
        if (wait_last) begin
          sj_d    = bus.q;
          state_d = StWrI;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWrI: state_d = StWrJ;
      StWrJ: begin
        if (i_q == 8'hFF) begin
          state_d = StDone;
        end else begin
          i_d       = i_q + 8'd1;
          key_idx_d = (key_idx_q == 2'd2) ? 2'd0 : key_idx_q + 2'd1;
          state_d   = StRdI;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Port values are decoded from the next state so the memory sees registered signals.
  always_comb begin
    address_d = '0;
    data_d    = '0;
    wen_d     = 1'b0;
    busy_d    = 1'b1;
    finish_d  = (state_d == StDone);

    unique case (state_d)
      StIdle, StDone: busy_d = 1'b0;
      StRdI, StWtI, StCalcJ: address_d = i_d;
      StRdJ, StWtJ: address_d = j_d;
      StWrI: begin
        address_d = i_d;
        data_d    = sj_d;
        wen_d     = 1'b1;
      end
      StWrJ: begin
        address_d = j_d;
        data_d    = si_d;
        wen_d     = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      i_q       <= '0;
      j_q       <= '0;
      key_idx_q <= '0;
      si_q      <= '0;
      sj_q      <= '0;
      wait_q    <= '0;
      key_q     <= '0;
      address_q <= '0;
      data_q    <= '0;
      wen_q     <= 1'b0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      key_idx_q <= key_idx_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      wait_q    <= wait_d;
      key_q     <= key_d;
      address_q <= address_d;
      data_q    <= data_d;
      wen_q     <= wen_d;
      busy_q    <= busy_d;
      finish_q  <= finish_d;
    end
  end

  assign bus.address = address_q;
  assign bus.data    = data_q;
  assign bus.wen     = wen_q;
  assign bus.busy    = busy_q;
  assign bus.mem_req = busy_q;
  assign bus.finish  = finish_q;

endmodule
